sdram_arbiter: RTL and testbench

Two-master arbiter for the shared 16-bit SDRAM controller's Avalon-MM slave port. Master 0 is the VGA pixel reader (read-only, priority). Master 1 is the drawing/CPU-side port (read/write). The block registers one command at a time toward the SDRAM controller, tracks outstanding pipelined reads, and steers each returned word to the master that issued it. A bounded-starvation counter guarantees master 1 progress under continuous video traffic.

---
 rtl/sdram_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of the SDRAM controller's Avalon-MM slave: video reader (m0) has priority, draw port (m1) gets bounded starvation.
// Optional macro SDRAM_ARB_STATS_EN builds the grant/stall counters; otherwise the stat ports are tied to zero.
module sdram_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 8,
  parameter int MAX_CONSEC  = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   sd_address,
  output logic                sd_read,
  output logic                sd_write,
  output logic [DATA_W-1:0]   sd_writedata,
  output logic [DATA_W/8-1:0] sd_byteenable,
  input  logic                sd_waitrequest,
  input  logic [DATA_W-1:0]   sd_readdata,
  input  logic                sd_readdatavalid,
  output logic                err_orphan,
  output logic [15:0]         stat_m0_grants,
  output logic [15:0]         stat_m1_grants,
  output logic [15:0]         stat_stall,
  output logic                dbg_state
);
  // Handshake: a master's request is taken in the single cycle its waitrequest is low;
  // the sd_* command is then held until the controller drops sd_waitrequest.
  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(MAX_PENDING);
  localparam int CW   = PW + 1;
  localparam int KW   = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] MAX_P = CW'(MAX_PENDING);
  localparam logic [KW-1:0] MAX_K = KW'(MAX_CONSEC);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          consec_q, consec_d;
  logic [MAX_PENDING-1:0] tag_q, tag_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [ADDR_W-1:0]      sd_address_q, sd_address_d;
  logic                   sd_read_q, sd_read_d, sd_write_q, sd_write_d;
  logic [DATA_W-1:0]      sd_writedata_q, sd_writedata_d;
  logic [BE_W-1:0]        sd_byteenable_q, sd_byteenable_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   m0_rdv_q, m0_rdv_d, m1_rdv_q, m1_rdv_d;
  logic                   err_orphan_q, err_orphan_d;
  logic                   gnt0, gnt1, push, pop, room, m0_elig, m1_elig, m1_req;

  always_comb begin
    state_d         = state_q;
    consec_d        = consec_q;
    tag_d           = tag_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    sd_address_d    = sd_address_q;
    sd_read_d       = sd_read_q;
    sd_write_d      = sd_write_q;
    sd_writedata_d  = sd_writedata_q;
    sd_byteenable_d = sd_byteenable_q;
    rdata_d         = rdata_q;
    err_orphan_d    = err_orphan_q;
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    m1_req          = m1_read | m1_write;
    room            = count_q < MAX_P;
    m0_elig         = m0_read & room;
    m1_elig         = m1_read ? room : m1_write;

    unique case (state_q)
      IDLE: begin
        if (m1_elig && (!m0_read || consec_q == MAX_K)) gnt1 = 1'b1;
        else if (m0_elig)                               gnt0 = 1'b1;
        else if (m1_elig)                               gnt1 = 1'b1;

        if (gnt1 || !m1_req)             consec_d = '0;
        else if (gnt0 && consec_q != MAX_K) consec_d = consec_q + KW'(1);

        if (gnt0) begin
          state_d         = ISSUE;
          sd_address_d    = m0_address;
          sd_read_d       = 1'b1;
          sd_write_d      = 1'b0;
          sd_writedata_d  = '0;
          sd_byteenable_d = '1;
        end else if (gnt1) begin
          state_d         = ISSUE;
          sd_address_d    = m1_address;
          sd_read_d       = m1_read;
          sd_write_d      = ~m1_read;
          sd_writedata_d  = m1_writedata;
          sd_byteenable_d = m1_byteenable;
        end
      end
      ISSUE: begin
        if (!sd_waitrequest) begin
          state_d    = IDLE;
          sd_read_d  = 1'b0;
          sd_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Tag FIFO remembers which master owns each outstanding read, in issue order.
    push = gnt0 | (gnt1 & m1_read);
    pop  = sd_readdatavalid & (count_q != '0);
    if (push) begin
      tag_d[wr_ptr_q] = gnt1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      rdata_d  = sd_readdata;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    m0_rdv_d = pop & ~tag_q[rd_ptr_q];
    m1_rdv_d = pop &  tag_q[rd_ptr_q];
    if (sd_readdatavalid && count_q == '0) err_orphan_d = 1'b1;

    m0_waitrequest = ~gnt0;
    m1_waitrequest = ~gnt1;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      consec_q        <= '0;
      tag_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      sd_address_q    <= '0;
      sd_read_q       <= 1'b0;
      sd_write_q      <= 1'b0;
      sd_writedata_q  <= '0;
      sd_byteenable_q <= '0;
      rdata_q         <= '0;
      m0_rdv_q        <= 1'b0;
      m1_rdv_q        <= 1'b0;
      err_orphan_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      consec_q        <= consec_d;
      tag_q           <= tag_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      sd_address_q    <= sd_address_d;
      sd_read_q       <= sd_read_d;
      sd_write_q      <= sd_write_d;
      sd_writedata_q  <= sd_writedata_d;
      sd_byteenable_q <= sd_byteenable_d;
      rdata_q         <= rdata_d;
      m0_rdv_q        <= m0_rdv_d;
      m1_rdv_q        <= m1_rdv_d;
      err_orphan_q    <= err_orphan_d;
    end
  end

  assign sd_address       = sd_address_q;
  assign sd_read          = sd_read_q;
  assign sd_write         = sd_write_q;
  assign sd_writedata     = sd_writedata_q;
  assign sd_byteenable    = sd_byteenable_q;
  assign m0_readdata      = rdata_q;
  assign m1_readdata      = rdata_q;
  assign m0_readdatavalid = m0_rdv_q;
  assign m1_readdatavalid = m1_rdv_q;
  assign err_orphan       = err_orphan_q;
  assign dbg_state        = state_q;

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] st_m0_q, st_m0_d, st_m1_q, st_m1_d, st_stall_q, st_stall_d;

  always_comb begin
    st_m0_d    = st_m0_q + {15'd0, gnt0};
    st_m1_d    = st_m1_q + {15'd0, gnt1};
    st_stall_d = st_stall_q + {15'd0, (state_q == ISSUE) & sd_waitrequest};
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st_m0_q    <= '0;
      st_m1_q    <= '0;
      st_stall_q <= '0;
    end else begin
      st_m0_q    <= st_m0_d;
      st_m1_q    <= st_m1_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_m0_grants = st_m0_q;
  assign stat_m1_grants = st_m1_q;
  assign stat_stall     = st_stall_q;
`else
  assign stat_m0_grants = '0;
  assign stat_m1_grants = '0;
  assign stat_stall     = '0;
`endif
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: write hold, pipelined reads, fairness, tag steering, pending limit, orphans, reset.
module tb_sdram_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address, sd_address;
  logic              m0_read, m0_waitrequest, m0_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, m1_writedata, sd_writedata, sd_readdata;
  logic              m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic [1:0]        m1_byteenable, sd_byteenable;
  logic              sd_read, sd_write, sd_waitrequest, sd_readdatavalid;
  logic              err_orphan, dbg_state;
  logic [15:0]       stat_m0_grants, stat_m1_grants, stat_stall;

  int checks   = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  sdram_arbiter dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sd_address(sd_address), .sd_read(sd_read), .sd_write(sd_write),
    .sd_writedata(sd_writedata), .sd_byteenable(sd_byteenable),
    .sd_waitrequest(sd_waitrequest), .sd_readdata(sd_readdata), .sd_readdatavalid(sd_readdatavalid),
    .err_orphan(err_orphan), .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
    .stat_stall(stat_stall), .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    m0_address = '0; m0_read = 1'b0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    sd_waitrequest = 1'b0; sd_readdata = '0; sd_readdatavalid = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_m0_wait", 32'(m0_waitrequest), 1);
    chk("rst_m1_wait", 32'(m1_waitrequest), 1);
    chk("rst_sd_read", 32'(sd_read), 0);
    chk("rst_sd_write", 32'(sd_write), 0);
    chk("rst_sd_addr", 32'(sd_address), 0);
    chk("rst_sd_wdata", 32'(sd_writedata), 0);
    chk("rst_sd_be", 32'(sd_byteenable), 0);
    chk("rst_rdata", 32'(m0_readdata), 0);
    chk("rst_m0_rdv", 32'(m0_readdatavalid), 0);
    chk("rst_m1_rdv", 32'(m1_readdatavalid), 0);
    chk("rst_orphan", 32'(err_orphan), 0);
    chk("rst_stats", {stat_m0_grants, stat_m1_grants | stat_stall}, 0);
    reset = 1'b0;
    tick();

    // Single m1 write held by three stall cycles
    m1_write = 1'b1; m1_address = 25'h0001234; m1_writedata = 16'hBEEF; m1_byteenable = 2'b11;
    sd_waitrequest = 1'b1;
    settle();
    chk("wr_accept_m1_wait", 32'(m1_waitrequest), 0);
    chk("wr_accept_m0_wait", 32'(m0_waitrequest), 1);
    tick();
    m1_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sd_waitrequest = 1'b0;
      settle();
      chk("wr_sd_write", 32'(sd_write), 1);
      chk("wr_sd_read", 32'(sd_read), 0);
      chk("wr_sd_addr", 32'(sd_address), 32'h0001234);
      chk("wr_sd_wdata", 32'(sd_writedata), 32'hBEEF);
      chk("wr_sd_be", 32'(sd_byteenable), 3);
      chk("wr_hold_m1_wait", 32'(m1_waitrequest), 1);
      tick();
    end
    settle();
    chk("wr_done_sd_write", 32'(sd_write), 0);

    // Three pipelined m0 reads, each returned 3 cycles after issue
    for (int c = 0; c < 10; c++) begin
      m0_read          = (c <= 4);
      m0_address       = ADDR_W'(32'h10 + (c + 1) / 2);
      sd_readdatavalid = (c == 4 || c == 6 || c == 8);
      sd_readdata      = DATA_W'(32'hA0 + (c - 4) / 2);
      settle();
      chk("rd3_m0_wait", 32'(m0_waitrequest), (c == 0 || c == 2 || c == 4) ? 0 : 1);
      chk("rd3_m1_wait", 32'(m1_waitrequest), 1);
      if (c % 2 == 1 && c <= 5) begin
        chk("rd3_sd_read", 32'(sd_read), 1);
        chk("rd3_sd_addr", 32'(sd_address), 32'h10 + (c - 1) / 2);
      end
      chk("rd3_m0_rdv", 32'(m0_readdatavalid), (c == 5 || c == 7 || c == 9) ? 1 : 0);
      if (c == 5 || c == 7 || c == 9) chk("rd3_m0_data", 32'(m0_readdata), 32'hA0 + (c - 5) / 2);
      chk("rd3_m1_rdv", 32'(m1_readdatavalid), 0);
      tick();
    end
    sd_readdatavalid = 1'b0;

    // Both masters continuously requesting: m0 x4 then m1, twice
    for (int c = 0; c < 20; c++) begin
      m0_read = 1'b1; m0_address = 25'h100;
      m1_write = 1'b1; m1_address = 25'h200; m1_writedata = 16'h5555; m1_byteenable = 2'b11;
      settle();
      chk("fair_m0_wait", 32'(m0_waitrequest), (c % 2 == 0 && (c / 2) % 5 != 4) ? 0 : 1);
      chk("fair_m1_wait", 32'(m1_waitrequest), (c % 2 == 0 && (c / 2) % 5 == 4) ? 0 : 1);
      if (c % 2 == 1) chk("fair_sd_write", 32'(sd_write), ((c / 2) % 5 == 4) ? 1 : 0);
      tick();
    end
    m1_write = 1'b0;

    // Eight reads now outstanding: a ninth is held until one returns
    m0_address = 25'h300;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("full_m0_held", 32'(m0_waitrequest), 1);
      tick();
    end
    sd_readdatavalid = 1'b1; sd_readdata = 16'h0077;
    settle();
    chk("full_pop_cycle_held", 32'(m0_waitrequest), 1);
    tick();
    sd_readdatavalid = 1'b0;
    settle();
    chk("full_ninth_accept", 32'(m0_waitrequest), 0);
    chk("full_ret_rdv", 32'(m0_readdatavalid), 1);
    chk("full_ret_data", 32'(m0_readdata), 32'h77);
    tick();
    m0_read = 1'b0;
    settle();
    chk("full_sd_read", 32'(sd_read), 1);
    chk("full_sd_addr", 32'(sd_address), 32'h300);
    tick();

    // Drain the eight outstanding reads, all owned by m0
    for (int i = 0; i < 9; i++) begin
      sd_readdatavalid = (i < 8);
      sd_readdata      = DATA_W'(32'hD0 + i);
      settle();
      if (i > 0) begin
        chk("drain_m0_rdv", 32'(m0_readdatavalid), 1);
        chk("drain_m0_data", 32'(m0_readdata), 32'hD0 + i - 1);
      end
      chk("drain_m1_rdv", 32'(m1_readdatavalid), 0);
      tick();
    end
    sd_readdatavalid = 1'b0;
    settle();
    chk("drain_done_rdv", 32'(m0_readdatavalid), 0);
    chk("drain_no_orphan", 32'(err_orphan), 0);

    // Interleaved reads m0, m1, m0 steered by tag
    m0_read = 1'b1; m0_address = 25'h20;
    settle();
    chk("il_m0_accept", 32'(m0_waitrequest), 0);
    tick();
    m0_read = 1'b0; m1_read = 1'b1; m1_address = 25'h21;
    settle();
    tick();
    settle();
    chk("il_m1_accept", 32'(m1_waitrequest), 0);
    tick();
    m1_read = 1'b0; m0_read = 1'b1; m0_address = 25'h22;
    settle();
    chk("il_m1_sd_read", 32'(sd_read), 1);
    tick();
    settle();
    chk("il_m0b_accept", 32'(m0_waitrequest), 0);
    tick();
    m0_read = 1'b0; sd_readdatavalid = 1'b1; sd_readdata = 16'h0001;
    settle();
    tick();
    sd_readdata = 16'h0002;
    settle();
    chk("il_r1_m0_rdv", 32'(m0_readdatavalid), 1);
    chk("il_r1_m1_rdv", 32'(m1_readdatavalid), 0);
    chk("il_r1_data", 32'(m0_readdata), 1);
    tick();
    sd_readdata = 16'h0003;
    settle();
    chk("il_r2_m0_rdv", 32'(m0_readdatavalid), 0);
    chk("il_r2_m1_rdv", 32'(m1_readdatavalid), 1);
    chk("il_r2_data", 32'(m1_readdata), 2);
    tick();
    sd_readdatavalid = 1'b0;
    settle();
    chk("il_r3_m0_rdv", 32'(m0_readdatavalid), 1);
    chk("il_r3_m1_rdv", 32'(m1_readdatavalid), 0);
    chk("il_r3_data", 32'(m0_readdata), 3);
    tick();

`ifdef SDRAM_ARB_STATS_EN
    chk("stat_m0", 32'(stat_m0_grants), 14);
    chk("stat_m1", 32'(stat_m1_grants), 4);
    chk("stat_stall", 32'(stat_stall), 3);
`else
    chk("stat_m0", 32'(stat_m0_grants), 0);
    chk("stat_m1", 32'(stat_m1_grants), 0);
    chk("stat_stall", 32'(stat_stall), 0);
`endif

    // Orphan return with nothing pending
    chk("orph_before", 32'(err_orphan), 0);
    sd_readdatavalid = 1'b1; sd_readdata = 16'h00EE;
    settle();
    tick();
    sd_readdatavalid = 1'b0;
    settle();
    chk("orph_set", 32'(err_orphan), 1);
    chk("orph_no_m0_rdv", 32'(m0_readdatavalid), 0);
    chk("orph_no_m1_rdv", 32'(m1_readdatavalid), 0);
    repeat (3) tick();
    chk("orph_sticky", 32'(err_orphan), 1);
    reset = 1'b1;
    settle();
    chk("orph_cleared", 32'(err_orphan), 0);
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-transaction abandons the read; its late return is an orphan
    m0_read = 1'b1; m0_address = 25'h40; sd_waitrequest = 1'b1;
    settle();
    chk("mid_accept", 32'(m0_waitrequest), 0);
    tick();
    m0_read = 1'b0;
    settle();
    chk("mid_sd_read", 32'(sd_read), 1);
    reset = 1'b1;
    settle();
    chk("mid_rst_sd_read", 32'(sd_read), 0);
    chk("mid_rst_state", 32'(dbg_state), 0);
    tick();
    reset = 1'b0; sd_waitrequest = 1'b0;
    sd_readdatavalid = 1'b1; sd_readdata = 16'h0042;
    tick();
    sd_readdatavalid = 1'b0;
    settle();
    chk("mid_orphan", 32'(err_orphan), 1);
    chk("mid_no_rdv", 32'(m0_readdatavalid), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
